// File: rtl/bcd_down_counter.sv
// Six-digit BCD down counter with preset load, optional underflow wrap and a delayed DONE pulse.
// One clock from LOAD/EN to outputs; DONE rises one cycle after the count lands on 000000.
module bcd_down_counter #(
  parameter bit WRAP = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic       EN,
  input  logic [3:0] LD0,
  input  logic [3:0] LD1,
  input  logic [3:0] LD2,
  input  logic [3:0] LD3,
  input  logic [3:0] LD4,
  input  logic [3:0] LD5,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic [3:0] BCD4,
  output logic [3:0] BCD5,
  output logic       ZERO,
  output logic       DONE,
  output logic       ACTIVE
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q [6];
  logic [3:0] cnt_d [6];
  logic [3:0] ld_raw [6];
  logic [3:0] ld_clamp [6];
  logic [3:0] dec [6];
  logic       borrow;
  logic       ld_zero;
  logic       dec_zero;
  logic       pend_q, pend_d;
  logic       done_q, done_d;

  assign ld_raw[0] = LD0;
  assign ld_raw[1] = LD1;
  assign ld_raw[2] = LD2;
  assign ld_raw[3] = LD3;
  assign ld_raw[4] = LD4;
  assign ld_raw[5] = LD5;

  // Clamp presets and build the full six-digit borrow chain combinationally.
  always_comb begin
    borrow   = 1'b1;
    ld_zero  = 1'b1;
    dec_zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_clamp[i] = (ld_raw[i] > 4'd9) ? 4'd9 : ld_raw[i];
      if (ld_clamp[i] != 4'd0) ld_zero = 1'b0;
      if (borrow) begin
        if (cnt_q[i] == 4'd0) begin
          dec[i] = 4'd9;
        end else begin
          dec[i] = cnt_q[i] - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dec[i] = cnt_q[i];
      end
      if (dec[i] != 4'd0) dec_zero = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    done_d  = 1'b0;
    if (LOAD) begin
      cnt_d   = ld_clamp;
      state_d = ld_zero ? EXPIRED : COUNT;
    end else begin
      // A wrap out of EXPIRED cancels the pulse that would otherwise confirm zero.
      done_d = pend_q && !(WRAP && EN);
      case (state_q)
        COUNT: begin
          if (EN) begin
            cnt_d = dec;
            if (dec_zero) begin
              state_d = EXPIRED;
              pend_d  = 1'b1;
            end
          end
        end
        EXPIRED: begin
          if (WRAP && EN) begin
            for (int i = 0; i < 6; i++) cnt_d[i] = 4'd9;
            state_d = COUNT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign BCD0   = cnt_q[0];
  assign BCD1   = cnt_q[1];
  assign BCD2   = cnt_q[2];
  assign BCD3   = cnt_q[3];
  assign BCD4   = cnt_q[4];
  assign BCD5   = cnt_q[5];
  assign DONE   = done_q;
  assign ACTIVE = (state_q == COUNT);
  assign ZERO   = (cnt_q[0] == 4'd0) && (cnt_q[1] == 4'd0) && (cnt_q[2] == 4'd0) &&
                  (cnt_q[3] == 4'd0) && (cnt_q[4] == 4'd0) && (cnt_q[5] == 4'd0);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: one instance per WRAP setting, shared stimulus.
module tb_bcd_down_counter;

  logic       CLK, CLR, LOAD, EN;
  logic [3:0] LD0, LD1, LD2, LD3, LD4, LD5;
  logic [3:0] a0, a1, a2, a3, a4, a5;
  logic [3:0] b0, b1, b2, b3, b4, b5;
  logic       a_zero, a_done, a_act;
  logic       b_zero, b_done, b_act;
  int         checks;
  int         failures;

  bcd_down_counter #(.WRAP(1'b0)) dut_h (
    .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .EN(EN),
    .LD0(LD0), .LD1(LD1), .LD2(LD2), .LD3(LD3), .LD4(LD4), .LD5(LD5),
    .BCD0(a0), .BCD1(a1), .BCD2(a2), .BCD3(a3), .BCD4(a4), .BCD5(a5),
    .ZERO(a_zero), .DONE(a_done), .ACTIVE(a_act)
  );

  bcd_down_counter #(.WRAP(1'b1)) dut_w (
    .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .EN(EN),
    .LD0(LD0), .LD1(LD1), .LD2(LD2), .LD3(LD3), .LD4(LD4), .LD5(LD5),
    .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3), .BCD4(b4), .BCD5(b5),
    .ZERO(b_zero), .DONE(b_done), .ACTIVE(b_act)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed view {ACTIVE, DONE, ZERO, BCD5..BCD0}; a hex literal reads as the decimal count.
  function automatic logic [26:0] st(input logic act, input logic done, input logic zero,
                                     input logic [23:0] cnt);
    return {act, done, zero, cnt};
  endfunction

  task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_h(input string tag, input logic [26:0] exp);
    chk({tag, "_h"}, st(a_act, a_done, a_zero, {a5, a4, a3, a2, a1, a0}), exp);
  endtask

  task automatic chk_w(input string tag, input logic [26:0] exp);
    chk({tag, "_w"}, st(b_act, b_done, b_zero, {b5, b4, b3, b2, b1, b0}), exp);
  endtask

  task automatic chk_both(input string tag, input logic [26:0] exp);
    chk_h(tag, exp);
    chk_w(tag, exp);
  endtask

  task automatic set_ld(input logic [23:0] v);
    {LD5, LD4, LD3, LD2, LD1, LD0} = v;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    CLR  = 1'b1;
    LOAD = 1'b0;
    EN   = 1'b0;
    set_ld(24'h000000);
    tick();
    chk_both("reset", st(0, 0, 1, 24'h000000));

    // EN ignored in IDLE
    CLR = 1'b0;
    EN  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_both("idle_en", st(0, 0, 1, 24'h000000));
    end

    // Count 3 -> 0, DONE one cycle after zero appears
    EN = 1'b0; LOAD = 1'b1; set_ld(24'h000003);
    tick();
    chk_both("load3", st(1, 0, 0, 24'h000003));
    LOAD = 1'b0; EN = 1'b1;
    tick();
    chk_both("dec2", st(1, 0, 0, 24'h000002));
    tick();
    chk_both("dec1", st(1, 0, 0, 24'h000001));
    tick();
    chk_both("dec0", st(0, 0, 1, 24'h000000));
    EN = 1'b0;
    tick();
    chk_both("done_pulse", st(0, 1, 1, 24'h000000));
    tick();
    chk_both("done_drop", st(0, 0, 1, 24'h000000));

    // Expired behaviour: hold vs wrap to 999999
    EN = 1'b1;
    tick();
    chk_h("exp_hold", st(0, 0, 1, 24'h000000));
    chk_w("exp_wrap", st(1, 0, 0, 24'h999999));
    tick();
    chk_h("exp_hold2", st(0, 0, 1, 24'h000000));
    chk_w("wrap_dec", st(1, 0, 0, 24'h999998));
    EN = 1'b0;

    // Full-width borrow
    LOAD = 1'b1; set_ld(24'h100000);
    tick();
    chk_both("load100000", st(1, 0, 0, 24'h100000));
    LOAD = 1'b0; EN = 1'b1;
    tick();
    chk_both("borrow6", st(1, 0, 0, 24'h099999));
    EN = 1'b0;
    tick();
    chk_both("hold_en0", st(1, 0, 0, 24'h099999));

    // Clamping, and LOAD wins over EN
    LOAD = 1'b1; EN = 1'b1; set_ld(24'hF0000C);
    tick();
    chk_both("clamp", st(1, 0, 0, 24'h900009));
    EN = 1'b0; set_ld(24'hABCDEF);
    tick();
    chk_both("clamp_all", st(1, 0, 0, 24'h999999));
    set_ld(24'h000000);
    tick();
    chk_both("load_zero", st(0, 0, 1, 24'h000000));
    LOAD = 1'b0;
    tick();
    chk_both("load_zero_nodone", st(0, 0, 1, 24'h000000));

    // LOAD in the cycle DONE would rise suppresses it
    LOAD = 1'b1; EN = 1'b1; set_ld(24'h000001);
    tick();
    chk_both("load1_en", st(1, 0, 0, 24'h000001));
    LOAD = 1'b0;
    tick();
    chk_both("hit0", st(0, 0, 1, 24'h000000));
    EN = 1'b0; LOAD = 1'b1; set_ld(24'h000005);
    tick();
    chk_both("load_kills_done", st(1, 0, 0, 24'h000005));
    LOAD = 1'b0;
    tick();
    chk_both("after_kill", st(1, 0, 0, 24'h000005));

    // CLR aborts a pending DONE
    LOAD = 1'b1; set_ld(24'h000001);
    tick();
    LOAD = 1'b0; EN = 1'b1;
    tick();
    chk_both("pre_clr0", st(0, 0, 1, 24'h000000));
    CLR = 1'b1; EN = 1'b0;
    tick();
    chk_both("clr_abort", st(0, 0, 1, 24'h000000));
    CLR = 1'b0;
    tick();
    chk_both("clr_nodone", st(0, 0, 1, 24'h000000));

    // CLR beats a same-cycle LOAD and a mid-count run
    LOAD = 1'b1; set_ld(24'h000050);
    tick();
    LOAD = 1'b0; EN = 1'b1;
    tick();
    chk_both("dec49", st(1, 0, 0, 24'h000049));
    CLR = 1'b1; LOAD = 1'b1; set_ld(24'h000007);
    tick();
    chk_both("clr_over_load", st(0, 0, 1, 24'h000000));
    CLR = 1'b0; LOAD = 1'b0; EN = 1'b1;
    tick();
    chk_both("idle_after_clr", st(0, 0, 1, 24'h000000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 SHALL have parameter WRAP, default 0, meaning: 0 = halt at 000000, 1 = underflow from 000000 to 999999.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port LOAD, input, 1 bit: load the preset digits this cycle.
REQ-005 SHALL have port EN, input, 1 bit: decrement enable, one step per enabled cycle.
REQ-006 SHALL have ports LD0..LD5, input, 4 bits each: preset BCD digits, LD0 = least significant.
REQ-007 SHALL have ports BCD0..BCD5, output reg, 4 bits each: current count, BCD0 = least significant.
REQ-008 SHALL have port ZERO, output, 1 bit: high when all six BCD digits equal 0.
REQ-009 SHALL have port DONE, output reg, 1 bit: one-cycle pulse on reaching 000000 by decrement.
REQ-010 SHALL have port ACTIVE, output, 1 bit: high while the state is COUNT.

Function
REQ-011 SHALL implement states IDLE, COUNT and EXPIRED; ACTIVE and ZERO SHALL be decoded combinationally from registered state.
REQ-012 Priority SHALL be CLR > LOAD > EN.
REQ-013 On LOAD, each digit SHALL register LDn, clamped to 9 when LDn > 9; EN in the same cycle SHALL be ignored (no decrement).
REQ-014 LOAD SHALL be accepted in every state; next state = EXPIRED if the clamped preset is 000000, else COUNT; DONE SHALL stay 0 on any LOAD.
REQ-015 In IDLE, EN SHALL be ignored and the count SHALL hold.
REQ-016 In COUNT with EN=1, the count SHALL decrement by one decimal: BCD0 decrements; a digit at 0 becomes 9 and borrows from the next digit; the borrow chain spans all six digits in the same cycle.
REQ-017 In COUNT with EN=1 and count 000001, the next count SHALL be 000000, next state EXPIRED, and DONE SHALL be 1 for exactly the following cycle.
REQ-018 In COUNT with EN=0, the count and state SHALL hold.
REQ-019 In EXPIRED with WRAP=0, EN SHALL be ignored, the count SHALL hold at 000000, and DONE SHALL not re-assert.
REQ-020 In EXPIRED with WRAP=1 and EN=1, the count SHALL become 999999, the state SHALL become COUNT, and DONE SHALL stay 0.
REQ-021 DONE SHALL be 0 in every cycle not covered by REQ-017.
REQ-022 Outputs SHALL never show a non-BCD digit (A-F) under any input sequence.
REQ-023 Latency from a LOAD or EN edge to the updated BCD outputs SHALL be one clock.

Reset
REQ-024 When CLR=1 at a clock edge, BCD0..BCD5 SHALL become 0, DONE 0, and the state IDLE, giving ZERO=1 and ACTIVE=0.
REQ-025 CLR SHALL abort any operation mid-count, including a same-cycle LOAD or a pending DONE pulse.
REQ-026 No asynchronous reset path SHALL exist.

Verification
REQ-027 Reset, then EN=1 for 5 cycles -> count stays 000000, ZERO=1, ACTIVE=0, DONE=0.
REQ-028 LOAD 000003, then EN=1 for 3 cycles -> 000002, 000001, 000000; DONE=1 exactly one cycle after 000000 appears, then ACTIVE=0 and ZERO=1.
REQ-029 LOAD 100000, then EN=1 for 1 cycle -> 099999 (full six-digit borrow in one cycle).
REQ-030 LOAD with LD0=4'hC, LD5=4'hF, others 0 -> 900009; LOAD asserted with EN=1 -> no decrement in that cycle.
REQ-031 WRAP=1: count to 000000, then EN=1 -> 999999 with ACTIVE=1 and DONE=0; WRAP=0: same stimulus -> holds 000000.
REQ-032 LOAD 000001 with EN=1 on the next cycle, and CLR asserted on the following cycle -> count 000000, DONE=0, ACTIVE=0.
